// File: rtl/bp_nonsynth_cosim_matcher_if.sv
// Commit, writeback and retire bundle for the cosim matcher.
// The master side produces commits and writebacks and consumes retire packets.
interface bp_nonsynth_cosim_matcher_if #(
    parameter int unsigned vaddr_width_p   = 39,
    parameter int unsigned instr_width_p   = 32,
    parameter int unsigned data_width_p    = 64,
    parameter int unsigned rf_addr_width_p = 5,
    parameter int unsigned num_wb_ports_p  = 2
);
    localparam int unsigned port_width_lp = (num_wb_ports_p > 1) ? $clog2(num_wb_ports_p) : 1;

    logic                                      commit_v;
    logic [vaddr_width_p-1:0]                  commit_pc;
    logic [instr_width_p-1:0]                  commit_instr;
    logic                                      commit_wb;
    logic [port_width_lp-1:0]                  commit_port;
    logic [rf_addr_width_p-1:0]                commit_rd;
    logic                                      commit_trap;
    logic [63:0]                               commit_cause;

    logic [num_wb_ports_p-1:0]                 wb_v;
    logic [num_wb_ports_p*rf_addr_width_p-1:0] wb_rd;
    logic [num_wb_ports_p*data_width_p-1:0]    wb_data;

    logic                                      ret_v;
    logic                                      ret_ready;
    logic [vaddr_width_p-1:0]                  ret_pc;
    logic [instr_width_p-1:0]                  ret_instr;
    logic                                      ret_trap;
    logic [63:0]                               ret_cause;
    logic [data_width_p-1:0]                   ret_data;

    modport master (
        output commit_v, commit_pc, commit_instr, commit_wb, commit_port, commit_rd,
        output commit_trap, commit_cause, wb_v, wb_rd, wb_data, ret_ready,
        input  ret_v, ret_pc, ret_instr, ret_trap, ret_cause, ret_data
    );

    modport slave (
        input  commit_v, commit_pc, commit_instr, commit_wb, commit_port, commit_rd,
        input  commit_trap, commit_cause, wb_v, wb_rd, wb_data, ret_ready,
        output ret_v, ret_pc, ret_instr, ret_trap, ret_cause, ret_data
    );
endinterface

// File: rtl/bp_nonsynth_cosim_matcher.sv
// Pairs in-order commits with late writeback results per register file and register,
// and hands resolved retire packets to a checker; adds cap/drain, watchdog, sticky errors.
module bp_nonsynth_cosim_matcher #(
    parameter int unsigned vaddr_width_p   = 39,
    parameter int unsigned instr_width_p   = 32,
    parameter int unsigned data_width_p    = 64,
    parameter int unsigned rf_addr_width_p = 5,
    parameter int unsigned num_wb_ports_p  = 2,
    parameter int unsigned commit_els_p    = 16,
    parameter int unsigned wb_els_p        = 4,
    parameter int unsigned watchdog_p      = 4096
) (
    input  logic                       clk_i,
    input  logic                       reset_i,
    input  logic                       freeze_i,
    input  logic [31:0]                instr_cap_i,
    bp_nonsynth_cosim_matcher_if.slave bus_io,
    output logic [31:0]                ret_cnt_o,
    output logic                       done_o,
    output logic [2:0]                 err_o
);
    localparam int unsigned port_width_lp = (num_wb_ports_p > 1) ? $clog2(num_wb_ports_p) : 1;
    localparam int unsigned rf_els_lp     = 1 << rf_addr_width_p;
    localparam int unsigned c_ptr_lp      = $clog2(commit_els_p);
    localparam int unsigned wb_ptr_lp     = $clog2(wb_els_p);
    localparam int unsigned wd_width_lp   = $clog2(watchdog_p + 1);
    localparam logic [wd_width_lp-1:0] wd_last_lp = wd_width_lp'(watchdog_p - 1);

    typedef struct packed {
        logic [vaddr_width_p-1:0]   pc;
        logic [instr_width_p-1:0]   instr;
        logic                       wb;
        logic [port_width_lp-1:0]   port;
        logic [rf_addr_width_p-1:0] rd;
        logic                       trap;
        logic [63:0]                cause;
    } commit_t;

    typedef enum logic [2:0] {StIdle, StRun, StDrain, StDone, StError} state_e;

    state_e                  r_state;
    commit_t                 r_c_mem [commit_els_p];
    logic [c_ptr_lp:0]       r_c_wptr, r_c_rptr;
    logic [data_width_p-1:0] r_wb_mem [num_wb_ports_p][rf_els_lp][wb_els_p];
    logic [wb_ptr_lp:0]      r_wb_wptr [num_wb_ports_p][rf_els_lp];
    logic [wb_ptr_lp:0]      r_wb_rptr [num_wb_ports_p][rf_els_lp];
    logic [31:0]             r_ret_cnt;
    logic                    r_done;
    logic [2:0]              r_err;
    logic [wd_width_lp-1:0]  r_wd_cnt;

    logic w_active, w_c_empty, w_c_full, w_c_enq, w_c_ovf;
    logic w_head_rd0, w_head_needs_wb, w_wb_avail, w_ret_v, w_deq;
    logic w_blocked, w_wd_expire, w_cap_hit, w_wb_ovf;
    commit_t w_head, w_commit_in;
    logic [data_width_p-1:0] w_wb_head_data;
    logic [num_wb_ports_p-1:0][rf_els_lp-1:0] w_wb_empty, w_wb_full, w_wb_req, w_wb_enq, w_wb_deq;

    assign w_active  = (r_state == StRun) || (r_state == StDrain);
    assign w_c_empty = (r_c_wptr == r_c_rptr);
    assign w_c_full  = (r_c_wptr[c_ptr_lp] != r_c_rptr[c_ptr_lp]) &&
                       (r_c_wptr[c_ptr_lp-1:0] == r_c_rptr[c_ptr_lp-1:0]);
    assign w_head    = r_c_mem[r_c_rptr[c_ptr_lp-1:0]];

    // Integer x0 never produces a writeback, so such commits resolve immediately with zero.
    assign w_head_rd0      = (w_head.port == '0) && (w_head.rd == '0);
    assign w_head_needs_wb = w_head.wb && !w_head.trap && !w_head_rd0;

    assign w_ret_v     = w_active && !w_c_empty && (!w_head_needs_wb || w_wb_avail);
    assign w_deq       = w_ret_v && bus_io.ret_ready;
    assign w_c_enq     = (r_state == StRun) && bus_io.commit_v && (!w_c_full || w_deq);
    assign w_c_ovf     = (r_state == StRun) && bus_io.commit_v && w_c_full && !w_deq;
    assign w_blocked   = w_active && !w_c_empty && !w_deq;
    assign w_wd_expire = w_blocked && (r_wd_cnt == wd_last_lp);
    assign w_cap_hit   = (instr_cap_i != '0) && (r_ret_cnt == instr_cap_i);

    always_comb begin
        w_commit_in       = '0;
        w_commit_in.pc    = bus_io.commit_pc;
        w_commit_in.instr = bus_io.commit_instr;
        w_commit_in.wb    = bus_io.commit_wb;
        w_commit_in.port  = bus_io.commit_port;
        w_commit_in.rd    = bus_io.commit_rd;
        w_commit_in.trap  = bus_io.commit_trap;
        w_commit_in.cause = bus_io.commit_cause;
    end

    // Per-register FIFO status and head lookup; kept apart from enq/deq to avoid a comb loop.
    always_comb begin
        w_wb_empty     = '0;
        w_wb_full      = '0;
        w_wb_req       = '0;
        w_wb_avail     = 1'b0;
        w_wb_head_data = '0;
        for (int unsigned p = 0; p < num_wb_ports_p; p++) begin
            for (int unsigned r = 0; r < rf_els_lp; r++) begin
                w_wb_empty[p][r] = (r_wb_wptr[p][r] == r_wb_rptr[p][r]);
                w_wb_full[p][r]  = (r_wb_wptr[p][r][wb_ptr_lp] != r_wb_rptr[p][r][wb_ptr_lp]) &&
                                   (r_wb_wptr[p][r][wb_ptr_lp-1:0] == r_wb_rptr[p][r][wb_ptr_lp-1:0]);
                w_wb_req[p][r]   = w_active && bus_io.wb_v[p] && !((p == 0) && (r == 0)) &&
                    (32'(bus_io.wb_rd[p*rf_addr_width_p +: rf_addr_width_p]) == r);
                if ((32'(w_head.port) == p) && (32'(w_head.rd) == r)) begin
                    w_wb_avail     = !w_wb_empty[p][r];
                    w_wb_head_data = r_wb_mem[p][r][r_wb_rptr[p][r][wb_ptr_lp-1:0]];
                end
            end
        end
    end

    always_comb begin
        w_wb_enq = '0;
        w_wb_deq = '0;
        w_wb_ovf = 1'b0;
        for (int unsigned p = 0; p < num_wb_ports_p; p++) begin
            for (int unsigned r = 0; r < rf_els_lp; r++) begin
                w_wb_deq[p][r] = w_deq && w_head_needs_wb &&
                                 (32'(w_head.port) == p) && (32'(w_head.rd) == r);
                w_wb_enq[p][r] = w_wb_req[p][r] && (!w_wb_full[p][r] || w_wb_deq[p][r]);
                w_wb_ovf       = w_wb_ovf || (w_wb_req[p][r] && w_wb_full[p][r] && !w_wb_deq[p][r]);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (w_c_enq) begin
            r_c_mem[r_c_wptr[c_ptr_lp-1:0]] <= w_commit_in;
        end
        for (int unsigned p = 0; p < num_wb_ports_p; p++) begin
            for (int unsigned r = 0; r < rf_els_lp; r++) begin
                if (w_wb_enq[p][r]) begin
                    r_wb_mem[p][r][r_wb_wptr[p][r][wb_ptr_lp-1:0]] <=
                        bus_io.wb_data[p*data_width_p +: data_width_p];
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            r_state   <= StIdle;
            r_c_wptr  <= '0;
            r_c_rptr  <= '0;
            r_ret_cnt <= '0;
            r_done    <= 1'b0;
            r_err     <= '0;
            r_wd_cnt  <= '0;
            for (int unsigned p = 0; p < num_wb_ports_p; p++) begin
                for (int unsigned r = 0; r < rf_els_lp; r++) begin
                    r_wb_wptr[p][r] <= '0;
                    r_wb_rptr[p][r] <= '0;
                end
            end
        end else begin
            if (w_c_enq) r_c_wptr <= r_c_wptr + 1'b1;
            if (w_deq) begin
                r_c_rptr <= r_c_rptr + 1'b1;
                if (!w_head.trap && (r_ret_cnt != '1)) r_ret_cnt <= r_ret_cnt + 32'd1;
            end
            for (int unsigned p = 0; p < num_wb_ports_p; p++) begin
                for (int unsigned r = 0; r < rf_els_lp; r++) begin
                    if (w_wb_enq[p][r]) r_wb_wptr[p][r] <= r_wb_wptr[p][r] + 1'b1;
                    if (w_wb_deq[p][r]) r_wb_rptr[p][r] <= r_wb_rptr[p][r] + 1'b1;
                end
            end
            r_err[0] <= r_err[0] | w_c_ovf;
            r_err[1] <= r_err[1] | w_wb_ovf;
            r_wd_cnt <= w_blocked ? r_wd_cnt + 1'b1 : '0;
            case (r_state)
                StIdle: if (!freeze_i) r_state <= StRun;
                StRun: begin
                    if (w_wd_expire) begin
                        r_state  <= StError;
                        r_err[2] <= 1'b1;
                    end else if (w_cap_hit) begin
                        r_state <= StDrain;
                    end
                end
                StDrain: begin
                    if (w_wd_expire) begin
                        r_state  <= StError;
                        r_err[2] <= 1'b1;
                    end else if (w_c_empty) begin
                        r_state <= StDone;
                        r_done  <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus_io.ret_v     = w_ret_v;
    assign bus_io.ret_pc    = w_head.pc;
    assign bus_io.ret_instr = w_head.instr;
    assign bus_io.ret_trap  = w_head.trap;
    assign bus_io.ret_cause = w_head.cause;
    assign bus_io.ret_data  = w_head_needs_wb ? w_wb_head_data : '0;
    assign ret_cnt_o        = r_ret_cnt;
    assign done_o           = r_done;
    assign err_o            = r_err;
endmodule

// File: tb/tb_bp_nonsynth_cosim_matcher.sv
// Directed bench for the cosim matcher: matching, ordering, traps, cap/drain, overflow, watchdog.
module tb_bp_nonsynth_cosim_matcher;
    logic        clk_i = 1'b0;
    logic        reset_i;
    logic        freeze_i;
    logic [31:0] instr_cap_i;
    logic [31:0] ret_cnt_o;
    logic        done_o;
    logic [2:0]  err_o;
    int          n_checks = 0;
    int          n_errs = 0;

    bp_nonsynth_cosim_matcher_if bus ();

    bp_nonsynth_cosim_matcher #(
        .watchdog_p(64)
    ) dut (
        .clk_i      (clk_i),
        .reset_i    (reset_i),
        .freeze_i   (freeze_i),
        .instr_cap_i(instr_cap_i),
        .bus_io     (bus),
        .ret_cnt_o  (ret_cnt_o),
        .done_o     (done_o),
        .err_o      (err_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errs++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic commit(input logic [38:0] pc, input logic wb, input logic port,
                          input logic [4:0] rd, input logic trap, input logic [63:0] cause);
        bus.commit_v     = 1'b1;
        bus.commit_pc    = pc;
        bus.commit_instr = pc[31:0] ^ 32'h13;
        bus.commit_wb    = wb;
        bus.commit_port  = port;
        bus.commit_rd    = rd;
        bus.commit_trap  = trap;
        bus.commit_cause = cause;
        tick();
        bus.commit_v = 1'b0;
    endtask

    task automatic wb(input int unsigned port, input logic [4:0] rd, input logic [63:0] data);
        bus.wb_v                   = '0;
        bus.wb_v[port]             = 1'b1;
        bus.wb_rd[port*5 +: 5]     = rd;
        bus.wb_data[port*64 +: 64] = data;
        tick();
        bus.wb_v = '0;
    endtask

    task automatic retire_one();
        bus.ret_ready = 1'b1;
        tick();
        bus.ret_ready = 1'b0;
    endtask

    task automatic do_reset(input logic [31:0] cap);
        reset_i       = 1'b0;
        instr_cap_i   = cap;
        bus.ret_ready = 1'b0;
        tick();
        tick();
        reset_i  = 1'b1;
        freeze_i = 1'b0;
        tick();
    endtask

    initial begin
        reset_i = 1'b0;
        freeze_i = 1'b1;
        instr_cap_i = '0;
        bus.commit_v = 1'b0;
        bus.commit_pc = '0;
        bus.commit_instr = '0;
        bus.commit_wb = 1'b0;
        bus.commit_port = '0;
        bus.commit_rd = '0;
        bus.commit_trap = 1'b0;
        bus.commit_cause = '0;
        bus.wb_v = '0;
        bus.wb_rd = '0;
        bus.wb_data = '0;
        bus.ret_ready = 1'b0;
        tick();
        tick();
        chk("rst_ret_v", bus.ret_v, 0);
        chk("rst_cnt", ret_cnt_o, 0);
        chk("rst_done", done_o, 0);
        chk("rst_err", err_o, 0);

        // Frozen in IDLE: commit must be ignored
        reset_i = 1'b1;
        tick();
        commit(39'h900, 1'b0, 1'b0, 5'd0, 1'b0, 64'h0);
        tick();
        chk("idle_ignore", bus.ret_v, 0);
        freeze_i = 1'b0;
        tick();
        chk("run_empty", bus.ret_v, 0);

        // Single commit matched by a late writeback
        commit(39'h1000, 1'b1, 1'b0, 5'd5, 1'b0, 64'h0);
        chk("t1_wait0", bus.ret_v, 0);
        tick();
        tick();
        chk("t1_wait1", bus.ret_v, 0);
        wb(0, 5'd5, 64'h1234);
        chk("t1_v", bus.ret_v, 1);
        chk("t1_data", bus.ret_data, 64'h1234);
        chk("t1_pc", bus.ret_pc, 64'h1000);
        retire_one();
        chk("t1_pop", bus.ret_v, 0);
        chk("t1_cnt", ret_cnt_o, 1);

        // Two commits to the same register, checker stalled
        commit(39'h2000, 1'b1, 1'b0, 5'd5, 1'b0, 64'h0);
        commit(39'h2004, 1'b1, 1'b0, 5'd5, 1'b0, 64'h0);
        wb(0, 5'd5, 64'hA);
        wb(0, 5'd5, 64'hB);
        for (int i = 0; i < 5; i++) begin
            chk("t2_hold_v", bus.ret_v, 1);
            chk("t2_hold_data", bus.ret_data, 64'hA);
            chk("t2_hold_pc", bus.ret_pc, 64'h2000);
            tick();
        end
        bus.ret_ready = 1'b1;
        tick();
        chk("t2_second_v", bus.ret_v, 1);
        chk("t2_second_pc", bus.ret_pc, 64'h2004);
        chk("t2_second_data", bus.ret_data, 64'hB);
        tick();
        bus.ret_ready = 1'b0;
        chk("t2_empty", bus.ret_v, 0);
        chk("t2_cnt", ret_cnt_o, 3);

        // Trap with wb flag set must not consume the queued x5 result
        wb(0, 5'd5, 64'hC);
        commit(39'h3000, 1'b1, 1'b0, 5'd5, 1'b1, 64'h2);
        chk("t3_v", bus.ret_v, 1);
        chk("t3_trap", bus.ret_trap, 1);
        chk("t3_cause", bus.ret_cause, 64'h2);
        chk("t3_data", bus.ret_data, 0);
        retire_one();
        chk("t3_cnt", ret_cnt_o, 3);
        commit(39'h3004, 1'b1, 1'b0, 5'd5, 1'b0, 64'h0);
        chk("t3_nopop_v", bus.ret_v, 1);
        chk("t3_nopop_data", bus.ret_data, 64'hC);
        retire_one();
        chk("t3_cnt2", ret_cnt_o, 4);

        // Integer x0 resolves immediately with zero
        commit(39'h3008, 1'b1, 1'b0, 5'd0, 1'b0, 64'h0);
        chk("x0_v", bus.ret_v, 1);
        chk("x0_data", bus.ret_data, 0);
        retire_one();
        chk("x0_cnt", ret_cnt_o, 5);

        // Port 1 reg 0 is a real register; port 0 reg 0 writeback is discarded
        commit(39'h300C, 1'b1, 1'b1, 5'd0, 1'b0, 64'h0);
        chk("fp_wait", bus.ret_v, 0);
        bus.wb_v = 2'b11;
        bus.wb_rd = '0;
        bus.wb_data = {64'hF00D, 64'h77};
        tick();
        bus.wb_v = '0;
        chk("fp_v", bus.ret_v, 1);
        chk("fp_data", bus.ret_data, 64'hF00D);
        retire_one();
        chk("fp_cnt", ret_cnt_o, 6);

        // Cap of 3 with 5 queued: in-flight retire completes, rest drains, then DONE
        do_reset(32'd3);
        chk("cap_rst_cnt", ret_cnt_o, 0);
        for (int i = 0; i < 5; i++) commit(39'h4000 + 39'(4 * i), 1'b0, 1'b0, 5'd0, 1'b0, 64'h0);
        bus.ret_ready = 1'b1;
        tick();
        chk("cap_cnt1", ret_cnt_o, 1);
        tick();
        chk("cap_cnt2", ret_cnt_o, 2);
        tick();
        chk("cap_cnt3", ret_cnt_o, 3);
        chk("cap_pc3", bus.ret_pc, 64'h400C);
        chk("cap_done_early", done_o, 0);
        tick();
        chk("cap_cnt4", ret_cnt_o, 4);
        chk("cap_pc4", bus.ret_pc, 64'h4010);
        bus.commit_v = 1'b1;
        bus.commit_pc = 39'hBAD0;
        bus.commit_wb = 1'b0;
        bus.commit_trap = 1'b0;
        tick();
        bus.commit_v = 1'b0;
        chk("drain_cnt5", ret_cnt_o, 5);
        chk("drain_drop", bus.ret_v, 0);
        chk("drain_no_err", err_o, 0);
        tick();
        chk("cap_done", done_o, 1);
        commit(39'h4100, 1'b0, 1'b0, 5'd0, 1'b0, 64'h0);
        chk("done_ignore", bus.ret_v, 0);
        chk("done_cnt", ret_cnt_o, 5);
        bus.ret_ready = 1'b0;

        // Commit FIFO overflow: 17th dropped, first 16 retire in order
        do_reset(32'd0);
        for (int i = 0; i < 17; i++) commit(39'h5000 + 39'(4 * i), 1'b0, 1'b0, 5'd0, 1'b0, 64'h0);
        chk("ovf_err", err_o, 3'b001);
        bus.ret_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            chk("ovf_v", bus.ret_v, 1);
            chk("ovf_pc", bus.ret_pc, 64'h5000 + 64'(4 * i));
            tick();
        end
        bus.ret_ready = 1'b0;
        chk("ovf_empty", bus.ret_v, 0);
        chk("ovf_cnt", ret_cnt_o, 16);

        // Writeback FIFO overflow on port 1 reg 3
        do_reset(32'd0);
        chk("wbovf_rst_err", err_o, 0);
        for (int k = 1; k <= 5; k++) wb(1, 5'd3, 64'(k));
        chk("wbovf_err", err_o, 3'b010);
        bus.ret_ready = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            commit(39'h6000 + 39'(4 * k), 1'b1, 1'b1, 5'd3, 1'b0, 64'h0);
            chk("wbovf_v", bus.ret_v, 1);
            chk("wbovf_data", bus.ret_data, 64'(k));
        end
        tick();
        bus.ret_ready = 1'b0;
        chk("wbovf_empty", bus.ret_v, 0);
        chk("wbovf_cnt", ret_cnt_o, 4);

        // Watchdog: head waits forever on x7
        do_reset(32'd0);
        commit(39'h7000, 1'b1, 1'b0, 5'd7, 1'b0, 64'h0);
        repeat (63) tick();
        chk("wd_before", err_o, 0);
        chk("wd_before_v", bus.ret_v, 0);
        tick();
        chk("wd_err", err_o, 3'b100);
        chk("wd_v", bus.ret_v, 0);
        wb(0, 5'd7, 64'h1);
        chk("err_ignore_wb", bus.ret_v, 0);

        // Asynchronous reset mid-cycle clears everything at once
        #2;
        reset_i = 1'b0;
        #1;
        chk("arst_err", err_o, 0);
        chk("arst_cnt", ret_cnt_o, 0);
        chk("arst_done", done_o, 0);
        chk("arst_v", bus.ret_v, 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errs);
        $finish;
    end
endmodule
